// File: rtl/chip_vector_tester_if.sv
// Bundle of the tester's control, vector-ROM and socket signals.
// The master side (bench/host) drives the start controls, supplies ROM data
// and reads back the socket pins. The slave side is the tester itself.
interface chip_vector_tester_if #(
    parameter int NUM_PINS    = 14,
    parameter int NUM_CHIPS   = 4,
    parameter int MAX_VECTORS = 16
);
    localparam int CHIP_W  = $clog2(NUM_CHIPS);
    localparam int VIDX_W  = $clog2(MAX_VECTORS);
    localparam int VLEN_W  = $clog2(MAX_VECTORS + 1);
    localparam int VADDR_W = CHIP_W + VIDX_W;

    logic                  Run;
    logic [CHIP_W:0]       Chip_Sel;
    logic [VLEN_W-1:0]     Vec_Len;
    logic                  Loop;
    logic                  Vec_Rd;
    logic [VADDR_W-1:0]    Vec_Addr;
    logic [3*NUM_PINS-1:0] Vec_Data;
    logic [NUM_PINS-1:0]   Pin_OE;
    logic [NUM_PINS-1:0]   Pin_Out;
    logic [NUM_PINS-1:0]   Pin_In;
    logic                  Busy;
    logic                  Done;
    logic                  Pass;
    logic [VIDX_W-1:0]     Fail_Vec;
    logic [NUM_PINS-1:0]   Fail_Pins;
    logic [15:0]           Pass_Count;

    modport master (
        output Run, Chip_Sel, Vec_Len, Loop, Vec_Data, Pin_In,
        input  Vec_Rd, Vec_Addr, Pin_OE, Pin_Out, Busy, Done, Pass,
               Fail_Vec, Fail_Pins, Pass_Count
    );

    modport slave (
        input  Run, Chip_Sel, Vec_Len, Loop, Vec_Data, Pin_In,
        output Vec_Rd, Vec_Addr, Pin_OE, Pin_Out, Busy, Done, Pass,
               Fail_Vec, Fail_Pins, Pass_Count
    );
endinterface

// File: rtl/chip_vector_tester.sv
// Vector-driven DIP logic-chip tester: fetches {oe, drv, exp} vectors from a
// synchronous ROM, drives the socket, waits a settle time, then compares the
// synchronized pin readback against the expected levels on undriven pins.
// A one-cycle ARM state after Run gives the documented Run-to-CHECK latency.
module chip_vector_tester #(
    parameter int NUM_PINS      = 14,
    parameter int NUM_CHIPS     = 4,
    parameter int MAX_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 1000,
    parameter int GND_PIN       = 6,
    parameter int VCC_PIN       = 13
) (
    input  logic                Clk,
    input  logic                Reset,
    chip_vector_tester_if.slave bus
);
    localparam int CHIP_W  = $clog2(NUM_CHIPS);
    localparam int VIDX_W  = $clog2(MAX_VECTORS);
    localparam int VLEN_W  = $clog2(MAX_VECTORS + 1);
    localparam int VADDR_W = CHIP_W + VIDX_W;
    localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);

    localparam logic [NUM_PINS-1:0] PWR_MASK   = NUM_PINS'((1 << GND_PIN) | (1 << VCC_PIN));
    localparam logic [CHIP_W:0]     CHIP_LIMIT = (CHIP_W + 1)'(NUM_CHIPS);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CHECK, S_FETCH, S_LOAD, S_SETTLE, S_COMPARE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CHIP_W:0]     chip_q, chip_d;
    logic [VLEN_W-1:0]   len_q, len_d;
    logic [VIDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_PINS-1:0] pin_oe_q, pin_oe_d;
    logic [NUM_PINS-1:0] pin_out_q, pin_out_d;
    logic [NUM_PINS-1:0] exp_q, exp_d;
    logic [NUM_PINS-1:0] sync1_q, sync1_d;
    logic [NUM_PINS-1:0] sync2_q, sync2_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [VIDX_W-1:0]   fail_vec_q, fail_vec_d;
    logic [NUM_PINS-1:0] fail_pins_q, fail_pins_d;
    logic [15:0]         pass_count_q, pass_count_d;

    logic [NUM_PINS-1:0] miss;
    logic                last_vec;
    logic [15:0]         pass_count_inc;

    // Mismatches only on pins the tester is not driving; power pins never count.
    assign miss           = (sync2_q ^ exp_q) & ~pin_oe_q & ~PWR_MASK;
    assign last_vec       = (VLEN_W'(idx_q) + VLEN_W'(1)) >= len_q;
    assign pass_count_inc = (pass_count_q == 16'hFFFF) ? pass_count_q : pass_count_q + 16'd1;

    // Next-state and datapath updates for the test sequencer.
    always_comb begin
        state_d      = state_q;
        chip_d       = chip_q;
        len_d        = len_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pin_oe_d     = pin_oe_q;
        pin_out_d    = pin_out_q;
        exp_d        = exp_q;
        sync1_d      = bus.Pin_In;
        sync2_d      = sync1_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_vec_d   = fail_vec_q;
        fail_pins_d  = fail_pins_q;
        pass_count_d = pass_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Run) begin
                    chip_d       = bus.Chip_Sel;
                    len_d        = bus.Vec_Len;
                    idx_d        = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_vec_d   = '0;
                    fail_pins_d  = '0;
                    pass_count_d = '0;
                    state_d      = S_ARM;
                end
            end
            S_ARM: state_d = S_CHECK;
            S_CHECK: begin
                if (chip_q >= CHIP_LIMIT || len_q == '0) begin
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_pins_d = '0;
                    pin_oe_d    = '0;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                pin_oe_d  = bus.Vec_Data[3*NUM_PINS-1 -: NUM_PINS] & ~PWR_MASK;
                pin_out_d = bus.Vec_Data[2*NUM_PINS-1 -: NUM_PINS];
                exp_d     = bus.Vec_Data[NUM_PINS-1:0];
                cnt_d     = '0;
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPARE: begin
                if (miss != '0) begin
                    fail_vec_d  = idx_q;
                    fail_pins_d = miss;
                    pass_d      = 1'b0;
                    done_d      = 1'b1;
                    pin_oe_d    = '0;
                    state_d     = S_DONE;
                end else if (!last_vec) begin
                    idx_d   = idx_q + VIDX_W'(1);
                    state_d = S_FETCH;
                end else begin
                    pass_count_d = pass_count_inc;
                    if (bus.Loop) begin
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        pass_d   = 1'b1;
                        done_d   = 1'b1;
                        pin_oe_d = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset tri-states the socket immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            chip_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            pin_oe_q     <= '0;
            pin_out_q    <= '0;
            exp_q        <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= '0;
            fail_pins_q  <= '0;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            chip_q       <= chip_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pin_oe_q     <= pin_oe_d;
            pin_out_q    <= pin_out_d;
            exp_q        <= exp_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_vec_q   <= fail_vec_d;
            fail_pins_q  <= fail_pins_d;
            pass_count_q <= pass_count_d;
        end
    end

    assign bus.Vec_Rd     = (state_q == S_FETCH);
    assign bus.Vec_Addr   = VADDR_W'(chip_q[CHIP_W-1:0]) * VADDR_W'(MAX_VECTORS) + VADDR_W'(idx_q);
    assign bus.Pin_OE     = pin_oe_q;
    assign bus.Pin_Out    = pin_out_q;
    assign bus.Busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.Done       = done_q;
    assign bus.Pass       = pass_q;
    assign bus.Fail_Vec   = fail_vec_q;
    assign bus.Fail_Pins  = fail_pins_q;
    assign bus.Pass_Count = pass_count_q;
endmodule

// File: tb/tb_chip_vector_tester.sv
// Scoreboard bench for chip_vector_tester: a fake 7400 socket, a registered
// vector ROM, directed scenarios plus randomized runs checked against a
// vector-by-vector reference model of the tester's rules.
module tb_chip_vector_tester;
    localparam int NP   = 14;
    localparam int NC   = 4;
    localparam int MV   = 16;
    localparam int SC   = 4;
    localparam int VPER = SC + 3;
    localparam logic [NP-1:0] PWR = 14'h2040;

    typedef struct {
        logic          pass;
        int            fail_vec;
        logic [NP-1:0] fail_pins;
        int            count;
        int            lat;
        int            nrd;
    } exp_t;

    logic clk;
    logic rst_n;
    logic stuck3;
    int   cyc;
    int   run_edge;
    int   rd_seen;
    int   checks;
    int   errors;
    logic done_prev;
    exp_t sb[$];

    logic [3*NP-1:0] rom [0:NC*MV-1];
    logic [3*NP-1:0] rom_q;

    chip_vector_tester_if #(.NUM_PINS(NP), .NUM_CHIPS(NC), .MAX_VECTORS(MV)) bus ();

    chip_vector_tester #(
        .NUM_PINS(NP), .NUM_CHIPS(NC), .MAX_VECTORS(MV),
        .SETTLE_CYCLES(SC), .GND_PIN(6), .VCC_PIN(13)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    // Socket with a 7400: undriven pins pulled high, gate outputs follow their inputs.
    function automatic logic [NP-1:0] socket(input logic [NP-1:0] oe, input logic [NP-1:0] drv,
                                             input logic stuck);
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = oe[i] ? drv[i] : 1'b1;
        if (!oe[2])  v[2]  = ~(v[0] & v[1]);
        if (!oe[5])  v[5]  = ~(v[3] & v[4]);
        if (!oe[7])  v[7]  = ~(v[8] & v[9]);
        if (!oe[10]) v[10] = ~(v[11] & v[12]);
        v[6]  = 1'b0;
        v[13] = 1'b1;
        if (stuck) v[2] = 1'b1;
        return v;
    endfunction

    // Reference: walk the vectors pass by pass, stop at first mismatching vector.
    function automatic exp_t model(input int chip, input int len, input int passes, input logic stuck);
        exp_t e;
        logic [3*NP-1:0] w;
        logic [NP-1:0] oe, seen, miss;
        e = '{pass: 1'b0, fail_vec: 0, fail_pins: '0, count: 0, lat: 2, nrd: 0};
        if (chip >= NC || len == 0) return e;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < len; v++) begin
                w    = rom[chip * MV + v];
                oe   = w[3*NP-1 -: NP] & ~PWR;
                seen = socket(oe, w[2*NP-1 -: NP], stuck);
                miss = (seen ^ w[NP-1:0]) & ~oe & ~PWR;
                e.nrd++;
                if (miss != '0) begin
                    e.fail_vec  = v;
                    e.fail_pins = miss;
                    e.lat       = 2 + e.nrd * VPER;
                    return e;
                end
            end
            e.count++;
        end
        e.pass = 1'b1;
        e.lat  = 2 + e.nrd * VPER;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic start_run(input int chip, input int len, input logic loop,
                             input bit push, input exp_t e);
        @(negedge clk);
        bus.Run      = 1'b1;
        bus.Chip_Sel = 3'(chip);
        bus.Vec_Len  = 5'(len);
        bus.Loop     = loop;
        rd_seen      = 0;
        if (push) sb.push_back(e);
        @(negedge clk);
        run_edge = cyc;
        bus.Run  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no Done expected Done within %0d cycles", bound);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous vector ROM: data valid the cycle after the read strobe.
    always @(posedge clk) if (bus.Vec_Rd) rom_q <= rom[bus.Vec_Addr];
    assign bus.Vec_Data = rom_q;
    assign bus.Pin_In   = socket(bus.Pin_OE, bus.Pin_Out, stuck3);

    // Monitor: on every rising Done, pop the oldest expectation and compare.
    initial begin
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.Vec_Rd) rd_seen++;
            if (bus.Done && !done_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got Done expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_pass",       int'(bus.Pass),       int'(e.pass));
                    chk("done_fail_vec",   int'(bus.Fail_Vec),   e.fail_vec);
                    chk("done_fail_pins",  int'(bus.Fail_Pins),  int'(e.fail_pins));
                    chk("done_pass_count", int'(bus.Pass_Count), e.count);
                    chk("done_latency",    cyc - run_edge,       e.lat);
                    chk("done_vec_reads",  rd_seen,              e.nrd);
                    chk("done_pin_oe",     int'(bus.Pin_OE),     0);
                    chk("done_busy",       int'(bus.Busy),       0);
                end
            end
            done_prev = bus.Done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [NP-1:0] oe, drv, ex, pre_oe;
        int chip, len;
        checks = 0; errors = 0; cyc = 0; run_edge = 0; rd_seen = 0;
        stuck3 = 1'b0; rst_n = 1'b0;
        bus.Run = 1'b0; bus.Chip_Sel = '0; bus.Vec_Len = '0; bus.Loop = 1'b0;

        // ROM contents: chip 0 = NAND truth table then random, chip 1 consistent,
        // chip 2 mostly consistent, chip 3 two directed vectors then random.
        for (int i = 0; i < NC * MV; i++) begin
            oe  = NP'($urandom);
            drv = NP'($urandom);
            ex  = NP'($urandom);
            if (i / MV == 1 || i / MV == 2) begin
                ex = socket(oe & ~PWR, drv, 1'b0) ^ (NP'($urandom) & ((oe & ~PWR) | PWR));
                if (i / MV == 2 && $urandom_range(0, 4) == 0) ex[$urandom_range(0, NP - 1)] ^= 1'b1;
            end
            rom[i] = {oe, drv, ex};
        end
        for (int v = 0; v < 4; v++) begin
            drv = ((v >> 1) != 0 ? 14'h0909 : 14'h0) | ((v & 1) != 0 ? 14'h1212 : 14'h0);
            ex  = drv | ((v == 3) ? 14'h0 : 14'h04A4);
            rom[v] = {14'h1B1B, drv, ex};
        end
        rom[3*MV]     = {14'h3FFF, NP'($urandom), NP'($urandom)};
        rom[3*MV + 1] = {14'h0000, 14'h0000, socket(14'h0, 14'h0, 1'b0) ^ PWR};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",       int'(bus.Busy),       0);
        chk("rst_done",       int'(bus.Done),       0);
        chk("rst_pass",       int'(bus.Pass),       0);
        chk("rst_pin_oe",     int'(bus.Pin_OE),     0);
        chk("rst_pass_count", int'(bus.Pass_Count), 0);
        chk("rst_vec_rd",     int'(bus.Vec_Rd),     0);
        rst_n = 1'b1;

        // Good NAND, 4 vectors
        start_run(0, 4, 1'b0, 1'b1, '{1'b1, 0, 14'h0, 1, 30, 4});
        wait_done(200);

        // Pin 3 stuck high fails on the 1,1 vector
        stuck3 = 1'b1;
        start_run(0, 4, 1'b0, 1'b1, '{1'b0, 3, 14'h0004, 0, 30, 4});
        wait_done(200);
        stuck3 = 1'b0;

        // Out-of-range chip and zero length
        start_run(NC, 4, 1'b0, 1'b1, '{1'b0, 0, 14'h0, 0, 2, 0});
        wait_done(50);
        start_run(0, 0, 1'b0, 1'b1, '{1'b0, 0, 14'h0, 0, 2, 0});
        wait_done(50);

        // oe all ones and power-pin expectation flips
        start_run(3, 2, 1'b0, 1'b1, '{1'b1, 0, 14'h0, 1, 16, 2});
        begin
            int n;
            n = 0;
            while (bus.Pin_OE == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("oe_ones_power_masked", int'(bus.Pin_OE), int'(14'h1FBF));
        wait_done(200);

        // Soak: 3 looping passes, Loop dropped during the 4th; a Run during Busy is ignored
        start_run(0, 4, 1'b1, 1'b1, '{1'b1, 0, 14'h0, 4, 2 + 16 * VPER, 16});
        repeat (50) @(negedge clk);
        bus.Run = 1'b1; bus.Chip_Sel = 3'd5; bus.Vec_Len = 5'd0;
        @(negedge clk);
        bus.Run = 1'b0;
        repeat (49) @(negedge clk);
        bus.Loop = 1'b0;
        wait_done(300);

        // Reset during SETTLE of vector 2, then a fresh run
        start_run(0, 4, 1'b0, 1'b0, '{1'b0, 0, 14'h0, 0, 0, 0});
        repeat (19) @(negedge clk);
        pre_oe = bus.Pin_OE;
        chk("pre_reset_pin_oe", int'(pre_oe), int'(14'h1B1B));
        rst_n = 1'b0;
        #1;
        chk("async_rst_pin_oe", int'(bus.Pin_OE), 0);
        chk("async_rst_busy",   int'(bus.Busy),   0);
        chk("async_rst_done",   int'(bus.Done),   0);
        chk("async_rst_pass",   int'(bus.Pass),   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(0, 4, 1'b0, 1'b1, '{1'b1, 0, 14'h0, 1, 30, 4});
        wait_done(200);

        // Randomized runs against the reference model
        for (int r = 0; r < 24; r++) begin
            chip = $urandom_range(0, 5);
            len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MV);
            e    = model(chip, len, 1, 1'b0);
            start_run(chip, len, 1'b0, 1'b1, e);
            wait_done(2 + MV * VPER + 20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chip_vector_tester.md
# chip_vector_tester

Parametrised, vector-driven DIP logic-chip tester for the bench chip checker. For the selected chip it reads stimulus/expect vectors from an external synchronous vector ROM and drives them onto the tri-stated socket pins. After a programmable settle time it samples the pins and compares them, stopping at the first mismatch. It replaces per-chip hand-written checker blocks and adds bidirectional pin control, fail diagnostics and a continuous soak mode.

## Interface
- NUM_PINS, 14: socket pin count; bit i = package pin i+1.
- NUM_CHIPS, 4: chip types held in the vector ROM.
- MAX_VECTORS, 16: vector slots per chip.
- SETTLE_CYCLES, 1000: Clk cycles between drive and sample (≥1).
- GND_PIN, 6 / VCC_PIN, 13: bit indices of the power pins; never driven, never compared.
- Derived widths: CHIP_W = clog2(NUM_CHIPS), VIDX_W = clog2(MAX_VECTORS), VLEN_W = clog2(MAX_VECTORS+1), VADDR_W = CHIP_W+VIDX_W.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low.
- Run  in  1  active-high, one-cycle start pulse; already debounced and inverted upstream.
- Chip_Sel  in  CHIP_W+1  chip index; latched on start.
- Vec_Len  in  VLEN_W  number of vectors for the chip; latched on start.
- Loop  in  1  soak mode; sampled at the end of each full pass.
- Vec_Rd  out  1  ROM read strobe.
- Vec_Addr  out  VADDR_W  address = chip*MAX_VECTORS + idx.
- Vec_Data  in  3*NUM_PINS  {oe, drv, exp}; valid one cycle after Vec_Rd.
- Pin_OE  out  NUM_PINS  per-pin drive enable.
- Pin_Out  out  NUM_PINS  per-pin drive value.
- Pin_In  in  NUM_PINS  raw pin readback; asynchronous.
- Busy  out  1  test in progress.
- Done  out  1  result valid; held until the next accepted Run.
- Pass  out  1  result; valid while Done = 1.
- Fail_Vec  out  VIDX_W  index of the first failing vector.
- Fail_Pins  out  NUM_PINS  mismatch mask of that vector.
- Pass_Count  out  16  completed passing passes; saturates at 0xFFFF.

## Operation
- Reset clears every output and register to 0. Pins are tri-stated immediately and the FSM enters IDLE.
- Pin_In passes through a 2-FF synchronizer.
- IDLE: Run latches Chip_Sel and Vec_Len, clears Done, Pass, Fail_Vec, Fail_Pins and Pass_Count, sets idx = 0, and moves to CHECK.
- CHECK:
  - Chip_Sel ≥ NUM_CHIPS or Vec_Len = 0: go to DONE with Pass = 0 and Fail_Pins = 0.
  - Otherwise go to FETCH.
- FETCH: assert Vec_Rd for one cycle with the current Vec_Addr, then go to LOAD.
- LOAD: register the vector.
  - Pin_OE = oe with the GND_PIN and VCC_PIN bits forced to 0; Pin_Out = drv.
  - Clear the settle counter; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to COMPARE.
- COMPARE:
  - mask = ~Pin_OE, with the power bits cleared.
  - miss = (sync_in ^ exp) & mask.
  - miss ≠ 0: Fail_Vec = idx, Fail_Pins = miss, Pass = 0, go to DONE.
  - Otherwise, if idx < Vec_Len−1: idx++ and go to FETCH. Pins keep their previous values until the next LOAD, so there is no release glitch between vectors.
  - Last vector passes with Loop = 1: Pass_Count++ (saturating), idx = 0, go to FETCH.
  - Last vector passes with Loop = 0: Pass_Count++, Pass = 1, go to DONE.
- DONE: Pin_OE = 0, Busy = 0, Done = 1. The next Run restarts the test.
- Busy = 1 in every state except IDLE and DONE.
- Run asserted while Busy = 1 is ignored.

## Timing
- Run at edge 0: CHECK at edge 1, FETCH at edge 2, data captured and pins driven at edge 4 (end of LOAD).
- Per vector: 1 FETCH + 1 LOAD + SETTLE_CYCLES + 1 COMPARE = SETTLE_CYCLES+3 cycles.
- Sampling: the compare at the end of COMPARE sees Pin_In as it was 2 cycles earlier. SETTLE_CYCLES must cover the external propagation delay plus this synchronizer latency.
- Full pass: 2 + Vec_Len*(SETTLE_CYCLES+3) cycles from Run to Done.
- Done, Pass, Fail_* are registered and change on the same edge as the DONE entry.
- An out-of-range Chip_Sel or a zero Vec_Len gives Done 2 cycles after Run.
- Reset during any state: outputs are 0 asynchronously, and no Done pulse is produced.
- Loop deasserted mid-pass: takes effect at the end of the current pass.

## Test plan
- 7400 NAND, chip 0, Vec_Len = 4, fake socket model, SETTLE_CYCLES = 4 -> Done at 2+4*7 = 30 cycles after Run, Pass = 1, Pass_Count = 1, Pin_OE = 0 after Done.
- Same setup with pin 3 stuck at 1 -> Pass = 0, Fail_Vec = 3 (the 1,1 input vector), Fail_Pins = 14'h0004.
- Chip_Sel = NUM_CHIPS -> Done 2 cycles after Run, Pass = 0, no Vec_Rd pulse.
- Vec_Len = 0 -> Done 2 cycles after Run, Pass = 0, Fail_Pins = 0.
- Loop = 1 for 3 passes, then Loop dropped -> Pass_Count = 4, Pass = 1. A second Run during Busy is ignored.
- Reset asserted during SETTLE of vector 2 -> Pin_OE = 0 within the same cycle, Busy, Done and Pass = 0, FSM in IDLE. A fresh Run then completes normally.
- Vector with oe = all ones -> Pin_OE bits 6 and 13 are 0, and those pins are excluded from Fail_Pins.
